// File: rtl/balance_ctrl.sv
// Account balance controller: credits deposit pulses against a ceiling and
// serves one withdraw request at a time through a small check/debit handshake.
module balance_ctrl #(
    parameter int BAL_W    = 16,
    parameter int DEP_UNIT = 100,
    parameter int MAX_BAL  = 1000
) (
    input  logic             clk,
    input  logic             res,
    input  logic             count_up,
    input  logic             wdr_req,
    input  logic [BAL_W-1:0] wdr_amt,
    output logic             wdr_ack,
    output logic             wdr_ok,
    output logic             dep_rej,
    output logic [BAL_W-1:0] balance,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DEBIT,
        DONE,
        WAIT
    } state_t;

    localparam logic [BAL_W:0] DEP_EXT = (BAL_W + 1)'(DEP_UNIT);
    localparam logic [BAL_W:0] MAX_EXT = (BAL_W + 1)'(MAX_BAL);

    state_t           state;
    logic [BAL_W-1:0] amt_q;
    logic             grant_q;

    logic [BAL_W:0]   base_bal;
    logic [BAL_W:0]   credit_bal;
    logic             dep_fit;
    logic [BAL_W-1:0] bal_next;

    // Debit and credit merge into one update so a deposit landing in the DEBIT
    // cycle never overwrites the subtraction. CHECK guarantees amt_q <= balance.
    always_comb begin
        base_bal   = {1'b0, balance};
        if (state == DEBIT) begin
            base_bal = {1'b0, balance} - {1'b0, amt_q};
        end
        credit_bal = base_bal + DEP_EXT;
        dep_fit    = (credit_bal <= MAX_EXT);
        bal_next   = base_bal[BAL_W-1:0];
        if (count_up && dep_fit) begin
            bal_next = credit_bal[BAL_W-1:0];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock and checked first, so it wins
        // over any deposit or debit scheduled for the same edge.
        if (res) begin
            state   <= IDLE;
            balance <= '0;
            amt_q   <= '0;
            grant_q <= 1'b0;
            dep_rej <= 1'b0;
        end else begin
            balance <= bal_next;
            dep_rej <= count_up && !dep_fit;
            case (state)
                IDLE: begin
                    if (wdr_req) begin
                        amt_q   <= wdr_amt;
                        grant_q <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (amt_q != '0 && amt_q <= balance) begin
                        state <= DEBIT;
                    end else begin
                        grant_q <= 1'b0;
                        state   <= DONE;
                    end
                end
                DEBIT: begin
                    grant_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    state <= wdr_req ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!wdr_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore-decoded from the state register only.
    assign wdr_ack = (state == DONE);
    assign wdr_ok  = (state == DONE) && grant_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_balance_ctrl.sv
// Self-checking bench for balance_ctrl: a scoreboard holds the expected result
// of each withdraw, popped when the DUT acknowledges.
module tb_balance_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         res;
    logic         count_up;
    logic         wdr_req;
    logic [W-1:0] wdr_amt;
    logic         wdr_ack;
    logic         wdr_ok;
    logic         dep_rej;
    logic [W-1:0] balance;
    logic         busy;

    typedef struct {
        logic         ok;
        logic [W-1:0] bal;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    balance_ctrl #(.BAL_W(W), .DEP_UNIT(100), .MAX_BAL(1000)) dut (
        .clk      (clk),
        .res      (res),
        .count_up (count_up),
        .wdr_req  (wdr_req),
        .wdr_amt  (wdr_amt),
        .wdr_ack  (wdr_ack),
        .wdr_ok   (wdr_ok),
        .dep_rej  (dep_rej),
        .balance  (balance),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b1; count_up = 1'b1; wdr_req = 1'b1; wdr_amt = 16'd5;
        cyc(); cyc();
        checks++; if (balance !== 16'd0) begin errors++; $display("FAIL reset_balance got %0d want 0", balance); end
        checks++; if (wdr_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack got %b want 0", wdr_ack); end
        checks++; if (wdr_ok !== 1'b0)   begin errors++; $display("FAIL reset_ok got %b want 0", wdr_ok); end
        checks++; if (dep_rej !== 1'b0)  begin errors++; $display("FAIL reset_dep_rej got %b want 0", dep_rej); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        res = 1'b0; count_up = 1'b0; wdr_req = 1'b0; wdr_amt = '0;
        cyc();
    endtask

    // count_up held high for n cycles counts n deposits.
    task automatic deposit(input int n, input logic [W-1:0] exp_bal);
        count_up = 1'b1;
        repeat (n) begin
            cyc();
            checks++; if (dep_rej !== 1'b0) begin errors++; $display("FAIL deposit_dep_rej got %b want 0", dep_rej); end
        end
        count_up = 1'b0;
        cyc();
        checks++; if (balance !== exp_bal) begin errors++; $display("FAIL deposit_balance got %0d want %0d", balance, exp_bal); end
    endtask

    task automatic deposit_reject(input logic [W-1:0] exp_bal);
        count_up = 1'b1;
        cyc();
        checks++; if (balance !== exp_bal) begin errors++; $display("FAIL reject_balance got %0d want %0d", balance, exp_bal); end
        checks++; if (dep_rej !== 1'b1)    begin errors++; $display("FAIL reject_pulse got %b want 1", dep_rej); end
        count_up = 1'b0;
        cyc();
        checks++; if (dep_rej !== 1'b0)    begin errors++; $display("FAIL reject_single got %b want 0", dep_rej); end
        checks++; if (balance !== exp_bal) begin errors++; $display("FAIL reject_hold got %0d want %0d", balance, exp_bal); end
    endtask

    // dep_at: cycle after the sample edge whose closing edge sees count_up
    // (1 = CHECK edge, 2 = DEBIT edge). chk_n/chk_bal: optional mid-flight
    // balance check. hold: extra cycles wdr_req stays high after the ack.
    task automatic withdraw(input logic [W-1:0] amt, input int dep_at,
                            input int chk_n, input logic [W-1:0] chk_bal,
                            input logic exp_ok, input int exp_lat,
                            input logic [W-1:0] exp_bal, input int hold);
        exp_t e;
        int   n;
        bit   got;
        e.ok = exp_ok; e.bal = exp_bal; e.lat = exp_lat;
        sb.push_back(e);
        wdr_req = 1'b1;
        wdr_amt = amt;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            cyc();
            n++;
            count_up = (n == dep_at);
            if (n == 1) wdr_amt = '1;
            if (n == chk_n) begin
                checks++; if (balance !== chk_bal) begin errors++; $display("FAIL mid_balance got %0d want %0d", balance, chk_bal); end
            end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_flight cycle %0d got %b want 1", n, busy); end
            if (wdr_ack === 1'b1) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL unexpected_ack got ack want none");
                end else begin
                    e = sb.pop_front();
                    checks++; if (n !== e.lat)      begin errors++; $display("FAIL ack_latency got %0d want %0d", n, e.lat); end
                    checks++; if (wdr_ok !== e.ok)  begin errors++; $display("FAIL wdr_ok got %b want %b", wdr_ok, e.ok); end
                    checks++; if (balance !== e.bal) begin errors++; $display("FAIL ack_balance got %0d want %0d", balance, e.bal); end
                end
            end
        end
        count_up = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout got no ack want ack within %0d cycles", exp_lat);
            void'(sb.pop_front());
        end
        repeat (hold) begin
            cyc();
            checks++; if (wdr_ack !== 1'b0) begin errors++; $display("FAIL wait_no_ack got %b want 0", wdr_ack); end
            checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
        end
        wdr_req = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        checks++; if (wdr_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got %b want 0", wdr_ack); end
    endtask

    task automatic test_withdraw_grant();
        withdraw(16'd200, 0, 0, '0, 1'b1, 3, 16'd100, 0);
    endtask

    task automatic test_withdraw_deny();
        withdraw(16'd150, 0, 0, '0, 1'b0, 2, 16'd100, 0);
        withdraw(16'd0,   0, 0, '0, 1'b0, 2, 16'd100, 0);
    endtask

    task automatic test_ceiling();
        deposit(9, 16'd1000);
        deposit_reject(16'd1000);
        // Deposit in the DEBIT cycle still breaks the ceiling: 950 + 100.
        withdraw(16'd50, 2, 0, '0, 1'b1, 3, 16'd950, 0);
        deposit_reject(16'd950);
    endtask

    task automatic test_debit_deposit();
        withdraw(16'd450, 0, 0, '0, 1'b1, 3, 16'd500, 0);
        withdraw(16'd200, 2, 0, '0, 1'b1, 3, 16'd400, 0);
        deposit(1, 16'd500);
        withdraw(16'd200, 1, 2, 16'd600, 1'b1, 3, 16'd400, 2);
    endtask

    task automatic test_back_to_back();
        withdraw(16'd400, 0, 0, '0, 1'b1, 3, 16'd0, 0);
        withdraw(16'd1,   0, 0, '0, 1'b0, 2, 16'd0, 0);
        deposit(4, 16'd400);
    endtask

    task automatic test_reset_mid();
        wdr_req = 1'b1;
        wdr_amt = 16'd100;
        cyc(); cyc();
        res = 1'b1;
        count_up = 1'b1;
        cyc();
        checks++; if (balance !== 16'd0) begin errors++; $display("FAIL midreset_balance got %0d want 0", balance); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (wdr_ack !== 1'b0)  begin errors++; $display("FAIL midreset_ack got %b want 0", wdr_ack); end
        res = 1'b0;
        count_up = 1'b0;
        // wdr_req is still high and is taken as a fresh request.
        withdraw(16'd100, 0, 0, '0, 1'b0, 2, 16'd0, 0);
    endtask

    initial begin
        res = 1'b1; count_up = 1'b0; wdr_req = 1'b0; wdr_amt = '0;
        test_reset();
        deposit(3, 16'd300);
        test_withdraw_grant();
        test_withdraw_deny();
        test_ceiling();
        test_debit_deposit();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
